// File: rtl/priv_clint_1_13.sv
// -----------------------------------------------------------------------------
// priv_clint_1_13 -- core-local interruptor (CLINT), privilege block v1.13.
//
// Holds the memory-mapped msip, mtimecmp and mtime registers and sources the
// machine timer / software interrupt levels plus one-cycle clear strobes on
// their falling edges. The data-side bus reaches it through a single-outstanding
// req/ack port: IDLE accepts a request, RESP acks it for one cycle, so at most
// one access completes every two cycles.
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x0000 msip (bit0)   0x4000/0x4004 mtimecmp lo/hi   0xBFF8/0xBFFC mtime lo/hi
//
// Parameters:
//   TICK_DIV   CLK cycles per mtime increment (1..65535)
//   BASE_CHECK 1: unmapped access returns err=1; 0: ignored, rdata=0, err=0
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   halt                debug freeze of prescaler/mtime (CLINT_HALT_EN only)
//   req, wen, addr, wdata   bus request (req held until ack)
//   rdata, ack, err         bus response, valid while ack=1
//   timer_int_m, soft_int_m                 pending interrupt levels
//   clear_timer_int_m, clear_soft_int_m     one-cycle falling-edge strobes
//
// Optional feature macro: CLINT_HALT_EN (adds the halt input).
// -----------------------------------------------------------------------------
module priv_clint_1_13 #(
  parameter int unsigned TICK_DIV   = 1,
  parameter bit          BASE_CHECK = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
`ifdef CLINT_HALT_EN
  input  logic        halt,
`endif
  input  logic        req,
  input  logic        wen,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        timer_int_m,
  output logic        soft_int_m,
  output logic        clear_timer_int_m,
  output logic        clear_soft_int_m
);

  localparam logic [15:0] PRESC_MAX   = 16'(TICK_DIV - 1);

  localparam logic [13:0] W_MSIP      = 14'h0000;
  localparam logic [13:0] W_CMP_LO    = 14'h1000;
  localparam logic [13:0] W_CMP_HI    = 14'h1001;
  localparam logic [13:0] W_MTIME_LO  = 14'h2FFE;
  localparam logic [13:0] W_MTIME_HI  = 14'h2FFF;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_q, state_d;

  logic        wen_p0;
  logic [13:0] word_p0;
  logic [31:0] wdata_p0;

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        msip_q, msip_d;
  logic        timer_d;

  logic        run, tick, accept, commit;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  // Address decode and read mux over the current register values; returns
  // {hit, data}.
  function automatic logic [32:0] read_word(input logic [13:0] w,
                                            input logic        msip,
                                            input logic [63:0] cmp,
                                            input logic [63:0] mt);
    logic [32:0] r;
    r = 33'd0;
    case (w)
      W_MSIP:     r = {1'b1, 31'd0, msip};
      W_CMP_LO:   r = {1'b1, cmp[31:0]};
      W_CMP_HI:   r = {1'b1, cmp[63:32]};
      W_MTIME_LO: r = {1'b1, mt[31:0]};
      W_MTIME_HI: r = {1'b1, mt[63:32]};
      default:    r = 33'd0;
    endcase
    return r;
  endfunction

`ifdef CLINT_HALT_EN
  assign run = ~halt;
`else
  assign run = 1'b1;
`endif

  assign tick   = run && (presc_q == PRESC_MAX);
  assign accept = (state_q == IDLE) && req;
  assign commit = (state_q == RESP) && wen_p0;
  assign ack    = (state_q == RESP);
  assign soft_int_m = msip_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    {rd_hit, rd_data} = read_word(addr[15:2], msip_q, cmp_q, mtime_q);

    presc_d = presc_q;
    if (run) presc_d = tick ? 16'd0 : presc_q + 16'd1;

    // A bus write to either mtime half replaces that half and drops this
    // cycle's increment, so no carry crosses into or out of the written half.
    mtime_d = mtime_q;
    if (commit && word_p0 == W_MTIME_LO)      mtime_d = {mtime_q[63:32], wdata_p0};
    else if (commit && word_p0 == W_MTIME_HI) mtime_d = {wdata_p0, mtime_q[31:0]};
    else if (tick)                            mtime_d = mtime_q + 64'd1;

    cmp_d = cmp_q;
    if (commit && word_p0 == W_CMP_LO) cmp_d = {cmp_q[63:32], wdata_p0};
    if (commit && word_p0 == W_CMP_HI) cmp_d = {wdata_p0, cmp_q[31:0]};

    msip_d = msip_q;
    if (commit && word_p0 == W_MSIP) msip_d = wdata_p0[0];

    // Compare on post-update values so a new mtimecmp takes effect on the
    // edge that commits it.
    timer_d = (mtime_d >= cmp_d);
  end

  // Request capture stage
  always_ff @(posedge CLK) begin
    if (accept) begin
      wen_p0   <= wen;
      word_p0  <= addr[15:2];
      wdata_p0 <= wdata;
    end
  end

  // Register file, FSM and response stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q           <= IDLE;
      presc_q           <= 16'd0;
      mtime_q           <= 64'd0;
      cmp_q             <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q            <= 1'b0;
      rdata             <= 32'd0;
      err               <= 1'b0;
      timer_int_m       <= 1'b0;
      clear_timer_int_m <= 1'b0;
      clear_soft_int_m  <= 1'b0;
    end else begin
      state_q           <= state_d;
      presc_q           <= presc_d;
      mtime_q           <= mtime_d;
      cmp_q             <= cmp_d;
      msip_q            <= msip_d;
      timer_int_m       <= timer_d;
      clear_timer_int_m <= timer_int_m & ~timer_d;
      clear_soft_int_m  <= msip_q & ~msip_d;
      if (accept) begin
        rdata <= (rd_hit && !wen) ? rd_data : 32'd0;
        err   <= BASE_CHECK & ~rd_hit;
      end else if (state_q == RESP) begin
        rdata <= 32'd0;
        err   <= 1'b0;
      end
    end
  end

endmodule
